// File: rtl/shift_requester.sv
// Initiator for the shift engine's write/ready pulse protocol: accepts one command, loads the engine, returns its result.
// Optional WAIT watchdog enabled by defining SHIFT_REQUESTER_TIMEOUT_EN.
module shift_requester #(
  parameter int DATA_WIDTH     = 16,
  parameter int AMT_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 20
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [DATA_WIDTH-1:0] req_data_i,
  input  logic [AMT_WIDTH-1:0]  req_amount_i,
  input  logic                  req_right_left_i,
  input  logic                  req_arith_logic_i,
  output logic                  sh_write_pulse_o,
  output logic [DATA_WIDTH-1:0] sh_data_o,
  output logic [AMT_WIDTH-1:0]  sh_amount_o,
  output logic                  sh_right_left_o,
  output logic                  sh_arith_logic_o,
  input  logic                  sh_ready_pulse_i,
  input  logic [DATA_WIDTH-1:0] sh_data_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic                  rsp_err_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t state;
  logic   first_wait;

`ifdef SHIFT_REQUESTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] wait_cnt;
`endif

  assign req_ready_o = (state == IDLE);
  assign busy_o      = (state != IDLE);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state            <= IDLE;
      first_wait       <= 1'b0;
      sh_write_pulse_o <= 1'b0;
      sh_data_o        <= '0;
      sh_amount_o      <= '0;
      sh_right_left_o  <= 1'b0;
      sh_arith_logic_o <= 1'b0;
      rsp_valid_o      <= 1'b0;
      rsp_data_o       <= '0;
      rsp_err_o        <= 1'b0;
`ifdef SHIFT_REQUESTER_TIMEOUT_EN
      wait_cnt         <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            sh_data_o        <= req_data_i;
            sh_amount_o      <= req_amount_i;
            sh_right_left_o  <= req_right_left_i;
            sh_arith_logic_o <= req_arith_logic_i;
            // The engine never answers a zero shift, so bypass it entirely.
            if (req_amount_i == '0) begin
              rsp_data_o  <= req_data_i;
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= 1'b0;
              state       <= RESP;
            end else begin
              sh_write_pulse_o <= 1'b1;
              state            <= ISSUE;
            end
          end
        end
        ISSUE: begin
          sh_write_pulse_o <= 1'b0;
          first_wait       <= 1'b1;
`ifdef SHIFT_REQUESTER_TIMEOUT_EN
          wait_cnt         <= '0;
`endif
          state            <= WAIT;
        end
        WAIT: begin
          first_wait <= 1'b0;
          // A pulse in the first WAIT cycle can only be left over from a previous operation.
          if (!first_wait && sh_ready_pulse_i) begin
            rsp_data_o  <= sh_data_i;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b0;
            state       <= RESP;
          end
`ifdef SHIFT_REQUESTER_TIMEOUT_EN
          else if (wait_cnt == CNT_LAST) begin
            rsp_data_o  <= '0;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b1;
            state       <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_requester.sv
// Self-checking bench for shift_requester: directed plan scenarios plus randomized commands vs. a shift reference model.
module tb_shift_requester;

  logic        clk = 1'b0;
  logic        reset_i, req_valid_i, req_right_left_i, req_arith_logic_i;
  logic        sh_ready_pulse_i, rsp_ready_i;
  logic [15:0] req_data_i, sh_data_i;
  logic [3:0]  req_amount_i;
  logic        req_ready_o, sh_write_pulse_o, sh_right_left_o, sh_arith_logic_o;
  logic        rsp_valid_o, rsp_err_o, busy_o;
  logic [15:0] sh_data_o, rsp_data_o;
  logic [3:0]  sh_amount_o;

  int checks = 0;
  int failures = 0;
  int wp_count = 0;

  shift_requester #(.DATA_WIDTH(16), .AMT_WIDTH(4), .TIMEOUT_CYCLES(20)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_data_i(req_data_i),
    .req_amount_i(req_amount_i), .req_right_left_i(req_right_left_i), .req_arith_logic_i(req_arith_logic_i),
    .sh_write_pulse_o(sh_write_pulse_o), .sh_data_o(sh_data_o), .sh_amount_o(sh_amount_o),
    .sh_right_left_o(sh_right_left_o), .sh_arith_logic_o(sh_arith_logic_o),
    .sh_ready_pulse_i(sh_ready_pulse_i), .sh_data_i(sh_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .rsp_err_o(rsp_err_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (sh_write_pulse_o === 1'b1) wp_count++;

  task automatic step;
    @(posedge clk); #1;
  endtask

  // What the shift engine would compute for a command.
  function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [3:0] a, input logic rl, input logic al);
    if (!rl) return d << a;
    if (al)  return 16'($signed(d) >>> a);
    return d >> a;
  endfunction

  task automatic run_cmd(input logic [15:0] d, input logic [3:0] a, input logic rl, input logic al,
                         input logic stale, input int hold);
    logic [15:0] exp;
    int wp0;
    exp = (a == 4'd0) ? d : ref_shift(d, a, rl, al);
    checks++; if (req_ready_o !== 1'b1) begin failures++; $display("FAIL cmd_ready got=%b exp=1", req_ready_o); end
    wp0 = wp_count;
    req_valid_i = 1'b1; req_data_i = d; req_amount_i = a; req_right_left_i = rl; req_arith_logic_i = al;
    step;
    req_valid_i = 1'b0; req_data_i = 16'($urandom); req_amount_i = 4'($urandom);
    req_right_left_i = 1'($urandom); req_arith_logic_i = 1'($urandom);
    checks++;
    if ({sh_data_o, sh_amount_o, sh_right_left_o, sh_arith_logic_o} !== {d, a, rl, al}) begin
      failures++; $display("FAIL operands got=%h/%h/%b/%b exp=%h/%h/%b/%b",
        sh_data_o, sh_amount_o, sh_right_left_o, sh_arith_logic_o, d, a, rl, al);
    end
    if (a == 4'd0) begin
      checks++;
      if (sh_write_pulse_o !== 1'b0 || rsp_valid_o !== 1'b1) begin
        failures++; $display("FAIL zero_amt got=wp%b rv%b exp=wp0 rv1", sh_write_pulse_o, rsp_valid_o);
      end
    end else begin
      checks++;
      if (sh_write_pulse_o !== 1'b1 || rsp_valid_o !== 1'b0 || busy_o !== 1'b1) begin
        failures++; $display("FAIL issue got=wp%b rv%b busy%b exp=wp1 rv0 busy1", sh_write_pulse_o, rsp_valid_o, busy_o);
      end
      step;
      // Engine answers in WAIT cycle amount+1; an optional stale pulse lands in WAIT cycle 1.
      for (int w = 1; w <= int'(a) + 1; w++) begin
        if (w == int'(a) + 1) begin sh_ready_pulse_i = 1'b1; sh_data_i = exp; end
        else if (w == 1 && stale) begin sh_ready_pulse_i = 1'b1; sh_data_i = ~exp; end
        step;
        sh_ready_pulse_i = 1'b0; sh_data_i = 16'($urandom);
        if (w < int'(a) + 1) begin
          checks++;
          if (rsp_valid_o !== 1'b0 || sh_write_pulse_o !== 1'b0 || busy_o !== 1'b1) begin
            failures++; $display("FAIL wait_%0d got=rv%b wp%b busy%b exp=rv0 wp0 busy1", w, rsp_valid_o, sh_write_pulse_o, busy_o);
          end
        end
      end
    end
    checks++;
    if (rsp_valid_o !== 1'b1 || rsp_data_o !== exp || rsp_err_o !== 1'b0) begin
      failures++; $display("FAIL resp got=rv%b %h err%b exp=rv1 %h err0", rsp_valid_o, rsp_data_o, rsp_err_o, exp);
    end
    for (int h = 0; h < hold; h++) begin
      step;
      checks++;
      if (rsp_valid_o !== 1'b1 || rsp_data_o !== exp || req_ready_o !== 1'b0 || busy_o !== 1'b1) begin
        failures++; $display("FAIL hold_%0d got=rv%b %h rr%b busy%b exp=rv1 %h rr0 busy1",
          h, rsp_valid_o, rsp_data_o, req_ready_o, busy_o, exp);
      end
    end
    rsp_ready_i = 1'b1;
    step;
    rsp_ready_i = 1'b0;
    checks++;
    if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1 || busy_o !== 1'b0 || rsp_err_o !== 1'b0) begin
      failures++; $display("FAIL ack got=rv%b rr%b busy%b err%b exp=rv0 rr1 busy0 err0", rsp_valid_o, req_ready_o, busy_o, rsp_err_o);
    end
    checks++;
    if (wp_count - wp0 !== int'(a != 4'd0)) begin
      failures++; $display("FAIL write_pulses got=%0d exp=%0d", wp_count - wp0, int'(a != 4'd0));
    end
    checks++;
    if (sh_data_o !== d || sh_amount_o !== a) begin
      failures++; $display("FAIL operand_hold got=%h/%h exp=%h/%h", sh_data_o, sh_amount_o, d, a);
    end
  endtask

  task automatic test_reset;
    reset_i = 1'b1;
    step; step;
    checks++;
    if ({sh_write_pulse_o, rsp_valid_o, rsp_err_o, rsp_data_o, sh_data_o, sh_amount_o, sh_right_left_o, sh_arith_logic_o} !== '0
        || req_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      failures++; $display("FAIL reset got=rv%b rd%h sd%h wp%b rr%b busy%b exp=all zero rr1 busy0",
        rsp_valid_o, rsp_data_o, sh_data_o, sh_write_pulse_o, req_ready_o, busy_o);
    end
    reset_i = 1'b0;
  endtask

  task automatic test_basic;
    run_cmd(16'h8001, 4'd3, 1'b1, 1'b1, 1'b0, 0);
  endtask

  task automatic test_zero_amount;
    run_cmd(16'h1234, 4'd0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_stale_pulse;
    run_cmd(16'h0004, 4'd1, 1'b1, 1'b0, 1'b1, 0);
  endtask

  task automatic test_backpressure;
    run_cmd(16'hA5A5, 4'd2, 1'b0, 1'b0, 1'b0, 5);
  endtask

  task automatic test_reset_mid_wait;
    req_valid_i = 1'b1; req_data_i = 16'hBEEF; req_amount_i = 4'd5; req_right_left_i = 1'b0; req_arith_logic_i = 1'b0;
    step;
    req_valid_i = 1'b0;
    step; step;
    reset_i = 1'b1;
    step;
    reset_i = 1'b0;
    sh_ready_pulse_i = 1'b1; sh_data_i = 16'hDEAD;
    step;
    sh_ready_pulse_i = 1'b0;
    step;
    checks++;
    if ({sh_write_pulse_o, rsp_valid_o, rsp_err_o, rsp_data_o, sh_data_o, sh_amount_o, sh_right_left_o, sh_arith_logic_o} !== '0
        || req_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      failures++; $display("FAIL abort got=rv%b rd%h sd%h rr%b busy%b exp=all zero rr1 busy0",
        rsp_valid_o, rsp_data_o, sh_data_o, req_ready_o, busy_o);
    end
    run_cmd(16'h00F0, 4'd4, 1'b0, 1'b0, 1'b0, 1);
  endtask

`ifdef SHIFT_REQUESTER_TIMEOUT_EN
  task automatic test_timeout;
    req_valid_i = 1'b1; req_data_i = 16'h5555; req_amount_i = 4'd7; req_right_left_i = 1'b1; req_arith_logic_i = 1'b0;
    step;
    req_valid_i = 1'b0;
    step;
    for (int w = 1; w <= 20; w++) begin
      step;
      if (w < 20) begin
        checks++;
        if (rsp_valid_o !== 1'b0) begin failures++; $display("FAIL timeout_early_%0d got=rv%b exp=rv0", w, rsp_valid_o); end
      end
    end
    checks++;
    if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b1 || rsp_data_o !== 16'h0000) begin
      failures++; $display("FAIL timeout got=rv%b err%b %h exp=rv1 err1 0000", rsp_valid_o, rsp_err_o, rsp_data_o);
    end
    rsp_ready_i = 1'b1;
    step;
    rsp_ready_i = 1'b0;
    checks++;
    if (rsp_err_o !== 1'b0 || req_ready_o !== 1'b1) begin
      failures++; $display("FAIL timeout_ack got=err%b rr%b exp=err0 rr1", rsp_err_o, req_ready_o);
    end
  endtask
`else
  task automatic test_no_pulse;
    req_valid_i = 1'b1; req_data_i = 16'h5555; req_amount_i = 4'd7; req_right_left_i = 1'b1; req_arith_logic_i = 1'b0;
    step;
    req_valid_i = 1'b0;
    repeat (30) step;
    checks++;
    if (rsp_valid_o !== 1'b0 || rsp_err_o !== 1'b0 || busy_o !== 1'b1) begin
      failures++; $display("FAIL no_pulse got=rv%b err%b busy%b exp=rv0 err0 busy1", rsp_valid_o, rsp_err_o, busy_o);
    end
    reset_i = 1'b1;
    step;
    reset_i = 1'b0;
  endtask
`endif

  task automatic test_random;
    logic [3:0] a;
    for (int n = 0; n < 25; n++) begin
      a = 4'($urandom_range(0, 15));
      run_cmd(16'($urandom), a, 1'($urandom), 1'($urandom), (a != 4'd0) && 1'($urandom), int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    reset_i = 1'b1; req_valid_i = 1'b0; req_data_i = '0; req_amount_i = '0;
    req_right_left_i = 1'b0; req_arith_logic_i = 1'b0;
    sh_ready_pulse_i = 1'b0; sh_data_i = '0; rsp_ready_i = 1'b0;
    test_reset;
    test_basic;
    test_zero_amount;
    test_stale_pulse;
    test_backpressure;
    test_reset_mid_wait;
`ifdef SHIFT_REQUESTER_TIMEOUT_EN
    test_timeout;
`else
    test_no_pulse;
`endif
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_requester.md
Name: shift_requester

Overview:
- Initiator side of the shift-engine write/ready pulse protocol. It accepts shift commands from an upstream master over a valid/ready handshake.
- It loads the shift engine with a single write pulse, then waits for the engine's ready pulse. It captures the shifted result and returns it on a valid/ready response channel.
- One command is in flight at a time. It sits between the control datapath and the serial shift engine.

Parameters:
- DATA_WIDTH, 16, operand/result width.
- AMT_WIDTH, 4, shift amount width. Maximum shift is 2**AMT_WIDTH-1.
- TIMEOUT_CYCLES, 20, WAIT-state watchdog limit. Used only with the optional feature.

Ports:
- clk_i  input  1  clock; all logic on rising edge
- reset_i  input  1  synchronous, active-high reset
- req_valid_i  input  1  upstream command valid
- req_ready_o  output  1  command accepted when req_valid_i & req_ready_o at clock edge
- req_data_i  input  DATA_WIDTH  operand
- req_amount_i  input  AMT_WIDTH  shift amount
- req_right_left_i  input  1  1 = right shift, 0 = left shift
- req_arith_logic_i  input  1  1 = arithmetic (right only), 0 = logical
- sh_write_pulse_o  output  1  one-cycle load strobe to shift engine
- sh_data_o  output  DATA_WIDTH  operand to engine
- sh_amount_o  output  AMT_WIDTH  amount to engine
- sh_right_left_o  output  1  direction to engine
- sh_arith_logic_o  output  1  mode to engine
- sh_ready_pulse_i  input  1  engine completion strobe; engine result is valid in the same cycle
- sh_data_i  input  DATA_WIDTH  engine result
- rsp_valid_o  output  1  response valid
- rsp_ready_i  input  1  downstream accepts response
- rsp_data_o  output  DATA_WIDTH  result
- rsp_err_o  output  1  timeout flag (optional feature)
- busy_o  output  1  high in any state other than IDLE

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP.
- req_ready_o = (state == IDLE). It is combinational decode of the state register only, with no dependency on req_valid_i.
- Reset (reset_i high at edge):
  - State goes to IDLE.
  - sh_write_pulse_o, rsp_valid_o, rsp_err_o = 0.
  - rsp_data_o, sh_data_o, sh_amount_o, sh_right_left_o, sh_arith_logic_o = 0.
  - Reset mid-operation aborts the command. No response is produced, and any later sh_ready_pulse_i is ignored until a new WAIT.
- IDLE, on accept:
  - Register all operands onto the sh_* outputs.
  - If req_amount_i == 0: rsp_data_o <= req_data_i, go to RESP. No write pulse is issued, because the engine never pulses ready for amount 0.
  - Otherwise go to ISSUE.
- ISSUE: sh_write_pulse_o = 1 for exactly this one cycle, then go to WAIT.
- Operand stability: the sh_* operand outputs hold stable from ISSUE until the next accept.
- WAIT, pulse qualification:
  - sh_ready_pulse_i is ignored in the first WAIT cycle. A stale pulse from a previous engine operation can appear there; a genuine pulse for amount >= 1 appears no earlier than the second WAIT cycle.
  - On any later WAIT cycle with sh_ready_pulse_i = 1: rsp_data_o <= sh_data_i, go to RESP.
- WAIT, expected timing: the genuine pulse arrives in WAIT cycle amount+1 after ISSUE, i.e. ISSUE-to-RESP latency = amount+1 edges.
- RESP:
  - rsp_valid_o = 1; rsp_data_o and rsp_err_o are held stable.
  - On rsp_ready_i: rsp_valid_o drops next cycle, rsp_err_o clears, go to IDLE.
  - req_ready_o is low in RESP, so accept and response never overlap; the new command is accepted in the following IDLE cycle at earliest.
- sh_ready_pulse_i in IDLE, ISSUE or RESP is ignored.
- No arithmetic is performed on data; widths pass through unchanged.

Optional Feature:
- Macro: SHIFT_REQUESTER_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without a qualified pulse, go to RESP with rsp_data_o = 0 and rsp_err_o = 1.
  - A pulse in the same cycle as the limit is reached wins: normal response, rsp_err_o = 0.
- Undefined: no counter; rsp_err_o tied 0; WAIT persists until a qualified pulse.

Test Plan:
- Reset, then a command with data 16'h8001, amount 3, right, arithmetic; engine model pulses 3 cycles after load and returns 16'hF000 -> exactly one sh_write_pulse_o; rsp_valid_o with rsp_data_o = 16'hF000 four edges after ISSUE; rsp_err_o = 0.
- Command with amount 0, data 16'h1234 -> no sh_write_pulse_o; rsp_valid_o the cycle after accept with rsp_data_o = 16'h1234.
- Inject sh_ready_pulse_i in the first WAIT cycle (stale), then a genuine pulse for amount 1 with sh_data_i = 16'h0002 -> stale pulse ignored; response 16'h0002.
- Hold rsp_ready_i low for 5 cycles -> rsp_valid_o and rsp_data_o stable, req_ready_o = 0 and busy_o = 1 throughout; after accept, IDLE and req_ready_o = 1.
- Assert reset_i during WAIT, then send a pulse -> no response; all outputs at reset values; the next command completes normally.
- With SHIFT_REQUESTER_TIMEOUT_EN and TIMEOUT_CYCLES = 20, the engine never pulses -> RESP after 20 WAIT cycles with rsp_err_o = 1 and rsp_data_o = 0.
